// File: rtl/tick_mon_pkg.sv
// Shared definitions for the tick period monitor.
//   state_t    : monitor FSM states
//   TICK_CNT_W : width of the free-running tick counter
//   clog2 / run_cnt_w : width helpers for the match-run counter
package tick_mon_pkg;

  localparam int unsigned TICK_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MEAS   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Smallest w with 2**w >= value, never less than 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) w = i + 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

  // Run counter has to hold 0..lock_count.
  function automatic int unsigned run_cnt_w(input int unsigned lock_count);
    return clog2(lock_count + 1);
  endfunction

endpackage

// File: rtl/tick_gap_counter.sv
// Saturating gap counter: cycles since the last tick.
//   clk, rst_n  : clock, asynchronous active-low reset
//   tick        : tick strobe, restarts the gap at 1
//   clear       : synchronous clear, gap to 0 (wins over tick)
//   gap         : current gap, saturates at TIMEOUT
//   at_timeout  : gap == TIMEOUT-1, i.e. the next tick-less cycle reaches TIMEOUT
module tick_gap_counter #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             clear,
  output logic [CNT_W-1:0] gap,
  output logic             at_timeout
);

  localparam logic [CNT_W-1:0] GAP_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] GAP_SAT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] GAP_PRE = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_gap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gap <= '0;
    end else if (clear) begin
      r_gap <= '0;
    end else if (tick) begin
      r_gap <= GAP_ONE;
    end else if (r_gap != GAP_SAT) begin
      r_gap <= r_gap + GAP_ONE;
    end
  end

  assign gap        = r_gap;
  assign at_timeout = (r_gap == GAP_PRE);

endmodule

// File: rtl/tick_period_monitor.sv
// Tick period monitor: measures cycles between ticks, reports each period,
// locks after LOCK_COUNT consecutive matching periods, flags lost ticks.
//   clk, rst_n    : clock, asynchronous active-low reset
//   clear         : synchronous clear to IDLE, outputs zeroed (wins over tick)
//   tick_in       : tick strobe, one tick per high cycle
//   period        : last measured period
//   period_valid  : one-cycle pulse when period updates
//   locked        : LOCK_COUNT consecutive periods within TOL
//   timeout       : one-cycle pulse when the gap reaches TIMEOUT
//   lost          : sticky copy of timeout, cleared by clear/rst_n
//   tick_count    : ticks since reset/clear, wrapping
// Build option TICK_MON_MINMAX_EN adds period_min / period_max outputs.
module tick_period_monitor
  import tick_mon_pkg::*;
#(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned TIMEOUT    = 1024,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned TOL        = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  tick_in,
  output logic [CNT_W-1:0]      period,
  output logic                  period_valid,
  output logic                  locked,
  output logic                  timeout,
  output logic                  lost,
  output logic [TICK_CNT_W-1:0] tick_count
`ifdef TICK_MON_MINMAX_EN
  ,
  output logic [CNT_W-1:0]      period_min,
  output logic [CNT_W-1:0]      period_max
`endif
);

  localparam int unsigned RUN_W = run_cnt_w(LOCK_COUNT);
  localparam logic [RUN_W-1:0]      RUN_ONE  = RUN_W'(1);
  localparam logic [RUN_W-1:0]      RUN_LOCK = RUN_W'(LOCK_COUNT);
  localparam logic [CNT_W:0]        TOL_X    = (CNT_W + 1)'(TOL);
  localparam logic [TICK_CNT_W-1:0] TCNT_ONE = TICK_CNT_W'(1);

  state_t                r_state;
  logic [RUN_W-1:0]      r_run;
  logic [CNT_W-1:0]      r_period;
  logic                  r_period_valid;
  logic                  r_locked;
  logic                  r_timeout;
  logic                  r_lost;
  logic [TICK_CNT_W-1:0] r_tick_count;

  logic [CNT_W-1:0] w_gap;
  logic             w_at_timeout;
  logic [CNT_W:0]   w_gap_x;
  logic [CNT_W:0]   w_prev_x;
  logic [CNT_W:0]   w_diff;
  logic             w_match;
  logic             w_load;
  logic             w_expire;
  logic [RUN_W-1:0] w_run_inc;
  logic [RUN_W-1:0] w_run_next;

  tick_gap_counter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_gap (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick_in),
    .clear      (clear),
    .gap        (w_gap),
    .at_timeout (w_at_timeout)
  );

  always_comb begin
    w_gap_x    = {1'b0, w_gap};
    w_prev_x   = {1'b0, r_period};
    w_diff     = (w_gap_x >= w_prev_x) ? (w_gap_x - w_prev_x) : (w_prev_x - w_gap_x);
    w_match    = (w_diff <= TOL_X);
    w_run_inc  = (r_run >= RUN_LOCK) ? RUN_LOCK : (r_run + RUN_ONE);
    // run==0 marks the first period after IDLE: nothing valid to compare with yet.
    w_run_next = ((r_run == '0) || !w_match) ? RUN_ONE : w_run_inc;
    w_load     = tick_in && !clear && (r_state != IDLE);
    // A tick on the pre-timeout cycle is a normal measurement, not a timeout.
    w_expire   = !tick_in && !clear && w_at_timeout && (r_state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_run          <= '0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
      r_locked       <= 1'b0;
      r_timeout      <= 1'b0;
      r_lost         <= 1'b0;
      r_tick_count   <= '0;
    end else if (clear) begin
      r_state        <= IDLE;
      r_run          <= '0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
      r_locked       <= 1'b0;
      r_timeout      <= 1'b0;
      r_lost         <= 1'b0;
      r_tick_count   <= '0;
    end else begin
      r_period_valid <= 1'b0;
      r_timeout      <= 1'b0;
      if (tick_in) r_tick_count <= r_tick_count + TCNT_ONE;

      if (w_load) begin
        r_period       <= w_gap;
        r_period_valid <= 1'b1;
      end

      if (w_expire) begin
        r_state   <= IDLE;
        r_run     <= '0;
        r_locked  <= 1'b0;
        r_timeout <= 1'b1;
        r_lost    <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            if (tick_in) begin
              r_state <= MEAS;
              r_run   <= '0;
            end
          end
          MEAS: begin
            if (tick_in) begin
              r_run <= w_run_next;
              if (w_run_next == RUN_LOCK) begin
                r_state  <= LOCKED;
                r_locked <= 1'b1;
              end
            end
          end
          LOCKED: begin
            if (tick_in) begin
              if (w_match) begin
                r_run <= w_run_inc;
              end else begin
                r_state  <= MEAS;
                r_run    <= RUN_ONE;
                r_locked <= 1'b0;
              end
            end
          end
          default: begin
            r_state  <= IDLE;
            r_run    <= '0;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign period       = r_period;
  assign period_valid = r_period_valid;
  assign locked       = r_locked;
  assign timeout      = r_timeout;
  assign lost         = r_lost;
  assign tick_count   = r_tick_count;

`ifdef TICK_MON_MINMAX_EN
  logic [CNT_W-1:0] r_min;
  logic [CNT_W-1:0] r_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_min <= '1;
      r_max <= '0;
    end else if (clear) begin
      r_min <= '1;
      r_max <= '0;
    end else if (w_load) begin
      if (w_gap < r_min) r_min <= w_gap;
      if (w_gap > r_max) r_max <= w_gap;
    end
  end

  assign period_min = r_min;
  assign period_max = r_max;
`else
  // Min/max tracking not built.
`endif

endmodule

// File: tb/tb_tick_period_monitor.sv
module tb_tick_period_monitor;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        tick_in;
  logic [31:0] period;
  logic        period_valid;
  logic        locked;
  logic        timeout;
  logic        lost;
  logic [15:0] tick_count;
`ifdef TICK_MON_MINMAX_EN
  logic [31:0] period_min;
  logic [31:0] period_max;
`endif

  tick_period_monitor #(
    .CNT_W      (32),
    .TIMEOUT    (1024),
    .LOCK_COUNT (4),
    .TOL        (0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .tick_in      (tick_in),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .timeout      (timeout),
    .lost         (lost),
    .tick_count   (tick_count)
`ifdef TICK_MON_MINMAX_EN
    ,
    .period_min   (period_min),
    .period_max   (period_max)
`endif
  );

  typedef struct {
    string       name;
    logic        clr;
    logic        tick;
    logic [31:0] p;
    logic        pv;
    logic        lk;
    logic        to;
    logic        lo;
    logic [15:0] tc;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(string name, bit clr, bit tick, int unsigned p,
                              bit pv, bit lk, bit to, bit lo, int unsigned tc);
    vec_t v;
    v.name = name;
    v.clr  = clr;
    v.tick = tick;
    v.p    = 32'(p);
    v.pv   = pv;
    v.lk   = lk;
    v.to   = to;
    v.lo   = lo;
    v.tc   = 16'(tc);
    return v;
  endfunction

  task automatic check_out();
    vec_t e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: no expectation queued");
      return;
    end
    e = sb.pop_front();
    if (period !== e.p || period_valid !== e.pv || locked !== e.lk ||
        timeout !== e.to || lost !== e.lo || tick_count !== e.tc) begin
      n_fail++;
      $display("FAIL %s @%0t: got p=%0d pv=%0b lk=%0b to=%0b lo=%0b tc=%0d, want p=%0d pv=%0b lk=%0b to=%0b lo=%0b tc=%0d",
               e.name, $time, period, period_valid, locked, timeout, lost, tick_count,
               e.p, e.pv, e.lk, e.to, e.lo, e.tc);
    end
  endtask

  task automatic apply(input vec_t v);
    clear   = v.clr;
    tick_in = v.tick;
    sb.push_back(v);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic check_zero(input string name);
    n_tests++;
    if (period !== '0 || period_valid !== 1'b0 || locked !== 1'b0 ||
        timeout !== 1'b0 || lost !== 1'b0 || tick_count !== '0) begin
      n_fail++;
      $display("FAIL %s: got p=%0d pv=%0b lk=%0b to=%0b lo=%0b tc=%0d, want all 0",
               name, period, period_valid, locked, timeout, lost, tick_count);
    end
`ifdef TICK_MON_MINMAX_EN
    n_tests++;
    if (period_min !== 32'hFFFF_FFFF || period_max !== 32'd0) begin
      n_fail++;
      $display("FAIL %s_minmax: got min=%0h max=%0h, want min=ffffffff max=0",
               name, period_min, period_max);
    end
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    clear   = 1'b0;
    tick_in = 1'b0;

    // Divider length 4, then a gap of 6 and relock, then clear+tick while locked.
    tbl.push_back(mk("t1_ref", 0, 1, 0, 0, 0, 0, 0, 1));
    for (int k = 0; k < 3; k++) tbl.push_back(mk("t1_gap0", 0, 0, 0, 0, 0, 0, 0, 1));
    for (int t = 2; t <= 5; t++) begin
      tbl.push_back(mk("t1_tick", 0, 1, 4, 1, (t == 5), 0, 0, t));
      if (t < 5)
        for (int k = 0; k < 3; k++) tbl.push_back(mk("t1_gap", 0, 0, 4, 0, 0, 0, 0, t));
    end
    for (int k = 0; k < 5; k++) tbl.push_back(mk("t3_gap6", 0, 0, 4, 0, 1, 0, 0, 5));
    tbl.push_back(mk("t3_p6", 0, 1, 6, 1, 0, 0, 0, 6));
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < 3; k++)
        tbl.push_back(mk("t3_gap", 0, 0, (j == 0) ? 6 : 4, 0, 0, 0, 0, 6 + j));
      tbl.push_back(mk("t3_relock", 0, 1, 4, 1, (j == 3), 0, 0, 7 + j));
    end
    tbl.push_back(mk("t5_clr_tick", 1, 1, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 2; k++) tbl.push_back(mk("t5_idle", 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("t5_ref", 0, 1, 0, 0, 0, 0, 0, 1));
    for (int k = 0; k < 3; k++) tbl.push_back(mk("t5_gap", 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk("t5_first", 0, 1, 4, 1, 0, 0, 0, 2));

    #12;
    check_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Held-high tick, then a 1023-cycle gap: measured, never a timeout.
    apply(mk("t2_clear", 1, 0, 0, 0, 0, 0, 0, 0));
    apply(mk("t2_ref", 0, 1, 0, 0, 0, 0, 0, 1));
    for (int c = 2; c <= 6; c++) apply(mk("t2_high", 0, 1, 1, 1, (c >= 5), 0, 0, c));
    for (int k = 1; k <= 1022; k++) apply(mk("gap1023_quiet", 0, 0, 1, 0, 1, 0, 0, 6));
    apply(mk("gap1023_tick", 0, 1, 1023, 1, 0, 0, 0, 7));

    // Lock, then ticks stop: timeout 1023 cycles after the last tick.
    apply(mk("t4_clear", 1, 0, 0, 0, 0, 0, 0, 0));
    apply(mk("t4_ref", 0, 1, 0, 0, 0, 0, 0, 1));
    for (int c = 2; c <= 5; c++) apply(mk("t4_high", 0, 1, 1, 1, (c == 5), 0, 0, c));
    for (int k = 1; k <= 1022; k++) apply(mk("t4_quiet", 0, 0, 1, 0, 1, 0, 0, 5));
    apply(mk("t4_timeout", 0, 0, 1, 0, 0, 1, 1, 5));
    for (int k = 0; k < 2; k++) apply(mk("t4_after", 0, 0, 1, 0, 0, 0, 1, 5));
    apply(mk("t4_ref_again", 0, 1, 1, 0, 0, 0, 1, 6));
    for (int k = 0; k < 3; k++) apply(mk("t4_gap", 0, 0, 1, 0, 0, 0, 1, 6));
    apply(mk("t4_first", 0, 1, 4, 1, 0, 0, 1, 7));

    // tick_count wraps 0xFFFF -> 0 with tick held high.
    apply(mk("wrap_clear", 1, 0, 0, 0, 0, 0, 0, 0));
    for (int c = 1; c <= 65537; c++)
      apply(mk("wrap", 0, 1, (c >= 2) ? 1 : 0, (c >= 2), (c >= 5), 0, 0, c));
    for (int k = 0; k < 2; k++) apply(mk("t6_gap", 0, 0, 1, 0, 1, 0, 0, 1));

    // Asynchronous reset mid-gap, away from any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("t6_async_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Periods 4, 7, 5.
    apply(mk("mm_ref", 0, 1, 0, 0, 0, 0, 0, 1));
    for (int k = 0; k < 3; k++) apply(mk("mm_gap", 0, 0, 0, 0, 0, 0, 0, 1));
    apply(mk("mm_p4", 0, 1, 4, 1, 0, 0, 0, 2));
    for (int k = 0; k < 6; k++) apply(mk("mm_gap", 0, 0, 4, 0, 0, 0, 0, 2));
    apply(mk("mm_p7", 0, 1, 7, 1, 0, 0, 0, 3));
    for (int k = 0; k < 4; k++) apply(mk("mm_gap", 0, 0, 7, 0, 0, 0, 0, 3));
    apply(mk("mm_p5", 0, 1, 5, 1, 0, 0, 0, 4));
`ifdef TICK_MON_MINMAX_EN
    n_tests++;
    if (period_min !== 32'd4 || period_max !== 32'd7) begin
      n_fail++;
      $display("FAIL minmax_457: got min=%0d max=%0d, want min=4 max=7", period_min, period_max);
    end
`endif

    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
